// File: rtl/ascii_hex_word_parser.sv
// Byte-stream ASCII hex parser: decodes hex/keypad characters from the UART RX
// path into nibbles and packs NUM_DIGITS of them into a word with line editing.
module ascii_hex_word_parser #(
    parameter int NUM_DIGITS  = 4,
    parameter int ALLOW_LOWER = 1,
    parameter int KEYPAD_MODE = 0,
    localparam int W  = 4 * NUM_DIGITS,
    localparam int CW = $clog2(NUM_DIGITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [W-1:0]  word_out,
    output logic          word_valid,
    output logic          err,
    output logic [CW-1:0] digit_cnt,
    output logic          discarding
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  acc, acc_nx, acc_sh, word_nx;
    logic [CW-1:0] cnt, cnt_nx, cnt_inc;
    logic          wv_nx, err_nx;
    logic          is_digit, is_term, is_bs, is_esc;
    logic [3:0]    nib;

    // Character classification; digits take priority over control codes.
    always_comb begin
        is_digit = 1'b0;
        nib      = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_digit = 1'b1;
            nib      = rx_data[3:0];
        end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
            is_digit = 1'b1;
            nib      = rx_data[3:0] + 4'd9;
        end else if (ALLOW_LOWER != 0 && rx_data >= 8'h61 && rx_data <= 8'h66) begin
            is_digit = 1'b1;
            nib      = rx_data[3:0] + 4'd9;
        end else if (KEYPAD_MODE != 0 && rx_data == 8'h2A) begin
            is_digit = 1'b1;
            nib      = 4'hE;
        end else if (KEYPAD_MODE != 0 && rx_data == 8'h23) begin
            is_digit = 1'b1;
            nib      = 4'hF;
        end
        is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
        is_bs   = (rx_data == 8'h08);
        is_esc  = (rx_data == 8'h1B);
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        word_nx  = word_out;
        wv_nx    = 1'b0;
        err_nx   = 1'b0;
        // Shift form avoids an empty slice when NUM_DIGITS is 1.
        acc_sh   = (acc << 4) | W'(nib);
        cnt_inc  = cnt + CW'(1);

        if (rx_valid) begin
            if (state == DISCARD) begin
                if (is_term || is_esc)
                    state_nx = IDLE;
            end else if (is_digit) begin
                if (cnt_inc == CW'(NUM_DIGITS)) begin
                    word_nx  = acc_sh;
                    wv_nx    = 1'b1;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    acc_nx   = acc_sh;
                    cnt_nx   = cnt_inc;
                    state_nx = ACCUM;
                end
            end else if (is_term) begin
                if (cnt != '0) begin
                    word_nx = acc;
                    wv_nx   = 1'b1;
                end
                acc_nx   = '0;
                cnt_nx   = '0;
                state_nx = IDLE;
            end else if (is_bs) begin
                if (cnt != '0) begin
                    acc_nx   = acc >> 4;
                    cnt_nx   = cnt - CW'(1);
                    state_nx = (cnt == CW'(1)) ? IDLE : ACCUM;
                end
            end else if (is_esc) begin
                acc_nx   = '0;
                cnt_nx   = '0;
                state_nx = IDLE;
            end else begin
                err_nx   = 1'b1;
                acc_nx   = '0;
                cnt_nx   = '0;
                state_nx = DISCARD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            cnt        <= cnt_nx;
            word_out   <= word_nx;
            word_valid <= wv_nx;
            err        <= err_nx;
        end
    end

    assign digit_cnt  = cnt;
    assign discarding = (state == DISCARD);

endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Directed bench for ascii_hex_word_parser: default 4-digit instance plus a
// 2-digit keypad instance with lowercase disabled.
module tb_ascii_hex_word_parser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] word_out;
    logic        word_valid, err, discarding;
    logic [2:0]  digit_cnt;

    logic [7:0]  rx_data2 = 8'h00;
    logic        rx_valid2 = 1'b0;
    logic [7:0]  word_out2;
    logic        word_valid2, err2, discarding2;
    logic [1:0]  digit_cnt2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    ascii_hex_word_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .word_out(word_out), .word_valid(word_valid), .err(err),
        .digit_cnt(digit_cnt), .discarding(discarding)
    );

    ascii_hex_word_parser #(.NUM_DIGITS(2), .ALLOW_LOWER(0), .KEYPAD_MODE(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .word_out(word_out2), .word_valid(word_valid2), .err(err2),
        .digit_cnt(digit_cnt2), .discarding(discarding2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte is driven at the falling edge and sampled at the next rising edge;
    // outputs are checked 1 ns after that edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge clk);
        rx_data2  = b;
        rx_valid2 = 1'b1;
        @(posedge clk);
        #1;
        rx_valid2 = 1'b0;
    endtask

    task automatic idle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_word", word_out, 16'h0000);
        chk("rst_wv", word_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_cnt", digit_cnt, 3'd0);
        chk("rst_disc", discarding, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word auto-commit
        send("1");
        chk("1A2F_cnt1", digit_cnt, 3'd1);
        chk("1A2F_wv0", word_valid, 1'b0);
        send("A"); send("2"); send("F");
        chk("1A2F_word", word_out, 16'h1A2F);
        chk("1A2F_wv", word_valid, 1'b1);
        chk("1A2F_cnt", digit_cnt, 3'd0);
        idle;
        chk("1A2F_wv_drop", word_valid, 1'b0);
        chk("1A2F_hold", word_out, 16'h1A2F);

        // Partial word, CR then LF
        send("3"); send("B");
        chk("3B_cnt", digit_cnt, 3'd2);
        send(8'h0D);
        chk("3B_word", word_out, 16'h003B);
        chk("3B_wv", word_valid, 1'b1);
        send(8'h0A);
        chk("LF_nopulse", word_valid, 1'b0);
        chk("LF_hold", word_out, 16'h003B);

        // Backspace
        send("1"); send("2"); send(8'h08);
        chk("bs_cnt", digit_cnt, 3'd1);
        send("7"); send(8'h0D);
        chk("bs_word", word_out, 16'h0017);
        chk("bs_wv", word_valid, 1'b1);
        send(8'h08);
        chk("bs_empty_cnt", digit_cnt, 3'd0);
        chk("bs_empty_err", err, 1'b0);

        // Escape
        send("5"); send(8'h1B);
        chk("esc_cnt", digit_cnt, 3'd0);
        chk("esc_err", err, 1'b0);
        send(8'h0D);
        chk("esc_cr_wv", word_valid, 1'b0);
        chk("esc_cr_hold", word_out, 16'h0017);

        // Error recovery
        send("4"); send("G");
        chk("G_err", err, 1'b1);
        chk("G_wv", word_valid, 1'b0);
        chk("G_disc", discarding, 1'b1);
        chk("G_cnt", digit_cnt, 3'd0);
        send("9");
        chk("disc_err0", err, 1'b0);
        chk("disc_cnt", digit_cnt, 3'd0);
        chk("disc_still", discarding, 1'b1);
        send("Z");
        chk("disc_inv_noerr", err, 1'b0);
        send(8'h0D);
        chk("disc_cr_wv", word_valid, 1'b0);
        chk("disc_cr_exit", discarding, 1'b0);
        chk("disc_cr_hold", word_out, 16'h0017);
        send("0"); send("0"); send("F"); send("F");
        chk("00FF_word", word_out, 16'h00FF);
        chk("00FF_wv", word_valid, 1'b1);

        // Lowercase allowed by default; keypad disabled by default
        send("a"); send("b"); send("c"); send("d");
        chk("lower_word", word_out, 16'hABCD);
        send("*");
        chk("star_err_kp0", err, 1'b1);
        chk("star_disc_kp0", discarding, 1'b1);
        send(8'h1B);
        chk("esc_exit_disc", discarding, 1'b0);
        chk("esc_exit_err", err, 1'b0);

        // Keypad instance, 2 digits, no lowercase
        send2("*");
        chk("kp_cnt1", digit_cnt2, 2'd1);
        send2("#");
        chk("kp_word", word_out2, 8'hEF);
        chk("kp_wv", word_valid2, 1'b1);
        chk("kp_cnt0", digit_cnt2, 2'd0);
        send2("a");
        chk("kp_lower_err", err2, 1'b1);
        chk("kp_lower_disc", discarding2, 1'b1);
        send2(8'h0A);
        chk("kp_lf_exit", discarding2, 1'b0);
        chk("kp_hold", word_out2, 8'hEF);

        // Async reset mid-word
        send("A"); send("B");
        chk("ab_cnt", digit_cnt, 3'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_word", word_out, 16'h0000);
        chk("arst_cnt", digit_cnt, 3'd0);
        chk("arst_wv", word_valid, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_disc", discarding, 1'b0);
        chk("arst_word2", word_out2, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle;
        chk("post_rst_wv", word_valid, 1'b0);
        send("0"); send("0"); send("0");
        chk("0001_cnt3", digit_cnt, 3'd3);
        send("1");
        chk("0001_word", word_out, 16'h0001);
        chk("0001_wv", word_valid, 1'b1);
        idle;
        chk("0001_wv_drop", word_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
